// File: rtl/mem_refill_unit_if.sv
// mem_refill_unit_if: single-word memory port between the refill unit and
// the backing data memory.
//   mem_req     unit -> mem  beat request (held until mem_ready)
//   mem_we      unit -> mem  1 = write beat, 0 = read beat
//   mem_address unit -> mem  word address of the beat
//   mem_wdata   unit -> mem  write beat data
//   mem_ready   mem -> unit  one-cycle beat completion
//   mem_rdata   mem -> unit  read data, valid while mem_ready is high
interface mem_refill_unit_if #(
  parameter int DATA_WIDTH    = 32,
  parameter int ADDRESS_WIDTH = 30
);
  logic                     mem_req;
  logic                     mem_we;
  logic [ADDRESS_WIDTH-1:0] mem_address;
  logic [DATA_WIDTH-1:0]    mem_wdata;
  logic                     mem_ready;
  logic [DATA_WIDTH-1:0]    mem_rdata;

  modport master (
    output mem_req, mem_we, mem_address, mem_wdata,
    input  mem_ready, mem_rdata
  );

  modport slave (
    input  mem_req, mem_we, mem_address, mem_wdata,
    output mem_ready, mem_rdata
  );
endinterface

// File: rtl/mem_refill_unit.sv
// mem_refill_unit: refill engine and write-through buffer between the data
// cache and backing memory. Misses fetch 2**BLOCK_SIZE words one beat at a
// time; stores are queued in a circular FIFO and drained before any refill.
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   miss_req/address    block miss request (level) and word address
//   refill_valid/data   one-cycle completion pulse and the fetched block
//   wr_req/address/data write-through store request
//   wbuf_full           buffer holds 2**WBUF_BITS entries
//   stall               pipeline freeze
//   mem                 memory beat port (master side)
module mem_refill_unit #(
  parameter int DATA_WIDTH    = 32,
  parameter int ADDRESS_WIDTH = 30,
  parameter int BLOCK_SIZE    = 1,
  parameter int WBUF_BITS     = 2
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 miss_req,
  input  logic [ADDRESS_WIDTH-1:0]             miss_address,
  output logic                                 refill_valid,
  output logic [DATA_WIDTH*(2**BLOCK_SIZE)-1:0] refill_data,
  input  logic                                 wr_req,
  input  logic [ADDRESS_WIDTH-1:0]             wr_address,
  input  logic [DATA_WIDTH-1:0]                wr_data,
  output logic                                 wbuf_full,
  output logic                                 stall,
  mem_refill_unit_if.master                    mem
);
  localparam int WORDS  = 2**BLOCK_SIZE;
  localparam int DEPTH  = 2**WBUF_BITS;
  localparam int BEAT_W = (BLOCK_SIZE > 0) ? BLOCK_SIZE : 1;
  localparam logic [WBUF_BITS:0]     DEPTH_C    = (WBUF_BITS+1)'(DEPTH);
  localparam logic [BEAT_W-1:0]      LAST_BEAT  = BEAT_W'(WORDS-1);
  localparam logic [ADDRESS_WIDTH-1:0] BLOCK_MASK = ADDRESS_WIDTH'(WORDS-1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    READ  = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t                     state_r;
  state_t                     state_next_s;
  logic                       push_s;
  logic                       pop_s;
  logic                       start_read_s;
  logic                       beat_done_s;
  logic                       last_beat_s;
  logic [WBUF_BITS-1:0]       head_r;
  logic [WBUF_BITS-1:0]       tail_r;
  logic [WBUF_BITS:0]         count_r;
  logic [ADDRESS_WIDTH-1:0]   wbuf_addr_r [DEPTH];
  logic [DATA_WIDTH-1:0]      wbuf_data_r [DEPTH];
  logic [BEAT_W-1:0]          beat_r;
  logic                       mem_req_r;
  logic                       mem_we_r;
  logic [ADDRESS_WIDTH-1:0]   mem_address_r;
  logic [DATA_WIDTH-1:0]      mem_wdata_r;
  logic [DATA_WIDTH*WORDS-1:0] refill_data_r;
  logic                       refill_valid_r;
  logic                       wbuf_full_s;

  // Occupancy is sampled at the start of the cycle, so a same-cycle pop
  // never makes room for a push into a full buffer.
  assign push_s      = wr_req && (count_r < DEPTH_C);
  assign wbuf_full_s = (count_r == DEPTH_C);
  assign beat_done_s = mem_req_r && mem.mem_ready;
  assign last_beat_s = (beat_r == LAST_BEAT);

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next-state logic and FIFO/refill control strobes.
  always_comb begin
    state_next_s = state_r;
    pop_s        = 1'b0;
    start_read_s = 1'b0;
    case (state_r)
      IDLE: begin
        // Pending stores always drain first so a refill never reads stale data;
        // a store arriving alongside the miss also defers the refill.
        if (count_r != {(WBUF_BITS+1){1'b0}}) begin
          pop_s        = 1'b1;
          state_next_s = WRITE;
        end else if (miss_req && !push_s) begin
          start_read_s = 1'b1;
          state_next_s = READ;
        end else begin
          state_next_s = IDLE;
        end
      end
      WRITE: begin
        if (beat_done_s) begin
          state_next_s = IDLE;
        end else begin
          state_next_s = WRITE;
        end
      end
      READ: begin
        if (beat_done_s && last_beat_s) begin
          state_next_s = DONE;
        end else begin
          state_next_s = READ;
        end
      end
      DONE: begin
        state_next_s = IDLE;
      end
      default: begin
        state_next_s = IDLE;
      end
    endcase
  end

  // Write-buffer pointers and occupancy.
  always_ff @(posedge clk) begin
    if (rst) begin
      head_r  <= {WBUF_BITS{1'b0}};
      tail_r  <= {WBUF_BITS{1'b0}};
      count_r <= {(WBUF_BITS+1){1'b0}};
    end else begin
      if (push_s) begin
        tail_r <= tail_r + WBUF_BITS'(1);
      end
      if (pop_s) begin
        head_r <= head_r + WBUF_BITS'(1);
      end
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + (WBUF_BITS+1)'(1);
        2'b01:   count_r <= count_r - (WBUF_BITS+1)'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  // Write-buffer storage; contents are don't-care until pushed.
  always_ff @(posedge clk) begin
    if (push_s) begin
      wbuf_addr_r[tail_r] <= wr_address;
      wbuf_data_r[tail_r] <= wr_data;
    end
  end

  // Registered memory port, beat sequencing and refill block assembly.
  always_ff @(posedge clk) begin
    if (rst) begin
      mem_req_r      <= 1'b0;
      mem_we_r       <= 1'b0;
      mem_address_r  <= {ADDRESS_WIDTH{1'b0}};
      mem_wdata_r    <= {DATA_WIDTH{1'b0}};
      beat_r         <= {BEAT_W{1'b0}};
      refill_data_r  <= {(DATA_WIDTH*WORDS){1'b0}};
      refill_valid_r <= 1'b0;
    end else begin
      mem_req_r      <= (state_next_s == WRITE) || (state_next_s == READ);
      mem_we_r       <= (state_next_s == WRITE);
      refill_valid_r <= (state_next_s == DONE);
      if (pop_s) begin
        mem_address_r <= wbuf_addr_r[head_r];
        mem_wdata_r   <= wbuf_data_r[head_r];
      end else if (start_read_s) begin
        // Block base has a zero offset, so beat increments never reach the tag.
        mem_address_r <= miss_address & ~BLOCK_MASK;
        beat_r        <= {BEAT_W{1'b0}};
      end else if ((state_r == READ) && beat_done_s && !last_beat_s) begin
        mem_address_r <= mem_address_r + ADDRESS_WIDTH'(1);
        beat_r        <= beat_r + BEAT_W'(1);
      end
      if ((state_r == READ) && beat_done_s) begin
        for (int i = 0; i < WORDS; i++) begin
          if (beat_r == BEAT_W'(i)) begin
            refill_data_r[i*DATA_WIDTH +: DATA_WIDTH] <= mem.mem_rdata;
          end
        end
      end
    end
  end

  assign mem.mem_req     = mem_req_r;
  assign mem.mem_we      = mem_we_r;
  assign mem.mem_address = mem_address_r;
  assign mem.mem_wdata   = mem_wdata_r;
  assign refill_valid    = refill_valid_r;
  assign refill_data     = refill_data_r;
  assign wbuf_full       = wbuf_full_s;
  assign stall           = rst ? 1'b0 : ((miss_req & ~refill_valid_r) | (wr_req & wbuf_full_s));
endmodule

// File: tb/tb_mem_refill_unit.sv
// Bench for mem_refill_unit: directed scenarios plus randomized stores and
// misses against a reference memory (shadow) that applies stores at the
// moment they are accepted, and a latency-randomized memory model.
module tb_mem_refill_unit;
  localparam int DW = 32;
  localparam int AW = 30;
  localparam int BS = 1;
  localparam int N  = 2**BS;
  localparam int WB = 2;

  typedef struct {
    bit [AW-1:0] a;
    bit [DW-1:0] d;
  } wr_t;

  logic            clk;
  logic            rst;
  logic            miss_req;
  logic [AW-1:0]   miss_address;
  logic            refill_valid;
  logic [DW*N-1:0] refill_data;
  logic            wr_req;
  logic [AW-1:0]   wr_address;
  logic [DW-1:0]   wr_data;
  logic            wbuf_full;
  logic            stall;

  mem_refill_unit_if #(.DATA_WIDTH(DW), .ADDRESS_WIDTH(AW)) mif ();

  mem_refill_unit #(.DATA_WIDTH(DW), .ADDRESS_WIDTH(AW), .BLOCK_SIZE(BS), .WBUF_BITS(WB)) dut (
    .clk(clk), .rst(rst),
    .miss_req(miss_req), .miss_address(miss_address),
    .refill_valid(refill_valid), .refill_data(refill_data),
    .wr_req(wr_req), .wr_address(wr_address), .wr_data(wr_data),
    .wbuf_full(wbuf_full), .stall(stall),
    .mem(mif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          n_tests = 0;
  int          n_fail  = 0;
  int          cyc     = 0;
  bit [DW-1:0] mem_a  [bit [AW-1:0]];
  bit [DW-1:0] shadow [bit [AW-1:0]];
  wr_t         exp_wr [$];
  int          wr_cyc [$];
  int          lat_fixed = 1;
  int          cur_lat   = 1;
  int          lat_cnt   = 0;
  bit          hold_off  = 1'b0;
  bit [AW-1:0] rd_base   = '0;
  int          rd_beat   = 0;
  int          rd0_cyc   = 0;
  int          rv_count  = 0;
  bit          last_accept, last_rv, last_stall, stall_seen;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Memory content: written words, otherwise address*3.
  function automatic bit [DW-1:0] peek(input bit from_shadow, input bit [AW-1:0] a);
    if (from_shadow) begin
      if (shadow.exists(a)) return shadow[a];
    end else begin
      if (mem_a.exists(a)) return mem_a[a];
    end
    return {2'b00, a} * 32'd3;
  endfunction

  task automatic set_lat(input int l);
    lat_fixed = l;
    cur_lat   = (l > 0) ? l : 1;
  endtask

  // Memory side for the cycle just started: beat completes L cycles after it began.
  task automatic mem_model();
    mif.mem_ready = 1'b0;
    mif.mem_rdata = $urandom;
    if (rst) begin
      lat_cnt = 0;
      return;
    end
    if (mif.mem_req) begin
      lat_cnt++;
      if (!hold_off && lat_cnt >= cur_lat) begin
        mif.mem_ready = 1'b1;
        lat_cnt = 0;
        cur_lat = (lat_fixed > 0) ? lat_fixed : int'($urandom_range(1, 3));
        if (mif.mem_we) begin
          wr_t e;
          check_eq("wr_expected", 64'(exp_wr.size() > 0), 64'd1);
          if (exp_wr.size() > 0) begin
            e = exp_wr.pop_front();
            check_eq("wr_addr", 64'(mif.mem_address), 64'(e.a));
            check_eq("wr_data", 64'(mif.mem_wdata), 64'(e.d));
          end
          mem_a[mif.mem_address] = mif.mem_wdata;
          wr_cyc.push_back(cyc);
        end else begin
          check_eq("rd_addr", 64'(mif.mem_address), 64'(rd_base + AW'(rd_beat)));
          if (rd_beat == 0) rd0_cyc = cyc;
          rd_beat++;
          mif.mem_rdata = peek(1'b0, mif.mem_address);
        end
      end
    end else if ($urandom_range(0, 7) == 0) begin
      mif.mem_ready = 1'b1;
    end
  endtask

  // Evaluate the current cycle's inputs, then advance one clock.
  task automatic tick();
    #1;
    last_accept = 1'b0;
    last_rv     = 1'b0;
    if (!rst) begin
      last_stall = stall;
      stall_seen = stall_seen | stall;
      check_eq("stall", 64'(stall), 64'((miss_req & ~refill_valid) | (wr_req & wbuf_full)));
      if (wr_req && !wbuf_full) begin
        exp_wr.push_back('{a: wr_address, d: wr_data});
        shadow[wr_address] = wr_data;
        last_accept = 1'b1;
      end
      if (refill_valid) begin
        last_rv = 1'b1;
        rv_count++;
        check_eq("rv_with_miss", 64'(miss_req), 64'd1);
        check_eq("rv_beats", 64'(rd_beat), 64'(N));
        check_eq("refill_data", refill_data, {peek(1'b1, rd_base + AW'(1)), peek(1'b1, rd_base)});
        rd_beat = 0;
      end
    end else begin
      check_eq("stall_rst", 64'(stall), 64'd0);
    end
    @(posedge clk);
    #1;
    cyc++;
    mem_model();
  endtask

  task automatic do_store(input bit [AW-1:0] a, input bit [DW-1:0] d);
    bit ok = 1'b0;
    wr_req = 1'b1; wr_address = a; wr_data = d;
    for (int i = 0; i < 200 && !ok; i++) begin
      tick();
      ok = last_accept;
    end
    wr_req = 1'b0;
    check_eq("store_accepted", 64'(ok), 64'd1);
  endtask

  // Miss held until refill_valid; lat = cycle of refill_valid (miss cycle = 0).
  task automatic do_miss(input bit [AW-1:0] a, input bit with_store, input bit [AW-1:0] sa,
                         input bit [DW-1:0] sd, output int lat, output bit [15:0] smask);
    bit done = 1'b0;
    lat = -1; smask = '0;
    rd_base = a & ~AW'(N-1);
    rd_beat = 0;
    miss_req = 1'b1; miss_address = a;
    if (with_store) begin
      wr_req = 1'b1; wr_address = sa; wr_data = sd;
    end
    for (int k = 0; k < 400 && !done; k++) begin
      tick();
      if (last_accept) wr_req = 1'b0;
      if (k < 16) smask[k] = last_stall;
      if (last_rv) begin
        done = 1'b1;
        lat = k;
      end
    end
    miss_req = 1'b0;
    wr_req   = 1'b0;
    check_eq("miss_done", 64'(done), 64'd1);
  endtask

  task automatic drain();
    for (int i = 0; i < 300 && (exp_wr.size() > 0 || mif.mem_req); i++) tick();
    check_eq("drain_empty", 64'(exp_wr.size()), 64'd0);
  endtask

  function automatic bit [AW-1:0] rand_addr();
    bit [3:0] lo = 4'($urandom);
    return ($urandom_range(0, 7) == 0) ? (30'h3FFFFFF0 | AW'(lo)) : AW'(lo);
  endfunction

  initial begin
    int lat, rv0;
    bit [15:0] sm;
    rst = 1'b1; miss_req = 1'b0; miss_address = '0;
    wr_req = 1'b0; wr_address = '0; wr_data = '0;
    mif.mem_ready = 1'b0; mif.mem_rdata = '0;
    @(posedge clk); #1;
    tick(); tick();
    rst = 1'b0;
    check_eq("rst_mem_req", 64'(mif.mem_req), 64'd0);
    check_eq("rst_mem_we", 64'(mif.mem_we), 64'd0);
    check_eq("rst_mem_address", 64'(mif.mem_address), 64'd0);
    check_eq("rst_refill_valid", 64'(refill_valid), 64'd0);
    check_eq("rst_wbuf_full", 64'(wbuf_full), 64'd0);
    check_eq("rst_refill_data", refill_data, 64'd0);

    // Refill of block 0x100 with L=2.
    set_lat(2);
    do_miss(30'h101, 1'b0, '0, '0, lat, sm);
    check_eq("refill_latency", 64'(lat), 64'd5);
    check_eq("refill_block", refill_data, 64'h00000303_00000300);
    check_eq("refill_stall", 64'(sm[5:0]), 64'h1f);

    // Three stores drained at L=1: one write every 2 cycles, no stall.
    set_lat(1);
    wr_cyc.delete(); stall_seen = 1'b0;
    do_store(30'h10, 32'hA); do_store(30'h11, 32'hB); do_store(30'h12, 32'hC);
    drain();
    check_eq("drain_writes", 64'(wr_cyc.size()), 64'd3);
    if (wr_cyc.size() == 3) begin
      check_eq("drain_gap1", 64'(wr_cyc[1] - wr_cyc[0]), 64'd2);
      check_eq("drain_gap2", 64'(wr_cyc[2] - wr_cyc[1]), 64'd2);
    end
    check_eq("drain_no_stall", 64'(stall_seen), 64'd0);
    check_eq("drain_mem_12", 64'(peek(1'b0, 30'h12)), 64'hC);

    // Full buffer: first store goes to the port (stuck), four more fill it.
    hold_off = 1'b1;
    for (int i = 0; i < 5; i++) begin
      do_store(AW'(30'h20 + i), DW'(32'h100 + i));
      if (i == 3) check_eq("not_full_3", 64'(wbuf_full), 64'd0);
    end
    check_eq("full_after_fill", 64'(wbuf_full), 64'd1);
    wr_req = 1'b1; wr_address = 30'h25; wr_data = 32'h105;
    for (int i = 0; i < 3; i++) begin
      tick();
      check_eq("full_reject", 64'(last_accept), 64'd0);
      check_eq("full_stall", 64'(last_stall), 64'd1);
    end
    wr_req = 1'b0;
    hold_off = 1'b0;
    do_store(30'h25, 32'h105);
    drain();
    check_eq("full_mem_25", 64'(peek(1'b0, 30'h25)), 64'h105);

    // Write before refill on the same block.
    set_lat(2);
    wr_cyc.delete();
    do_store(30'h200, 32'hDEAD);
    do_miss(30'h200, 1'b0, '0, '0, lat, sm);
    check_eq("wbr_latency", 64'(lat), 64'd8);
    check_eq("wbr_order", 64'(wr_cyc.size() == 1 && wr_cyc[0] < rd0_cyc), 64'd1);
    check_eq("wbr_word0", 64'(refill_data[31:0]), 64'hDEAD);
    check_eq("wbr_word1", 64'(refill_data[63:32]), 64'h603);

    // Miss and store in the same idle cycle: store first, refill deferred.
    do_miss(30'h301, 1'b1, 30'h300, 32'hBEEF, lat, sm);
    check_eq("same_cycle_latency", 64'(lat), 64'd9);
    check_eq("same_cycle_block", refill_data, 64'h00000903_0000BEEF);

    // Back-to-back misses.
    set_lat(1);
    rv0 = rv_count;
    do_miss(30'h120, 1'b0, '0, '0, lat, sm);
    check_eq("b2b_lat1", 64'(lat), 64'd3);
    do_miss(30'h122, 1'b0, '0, '0, lat, sm);
    check_eq("b2b_lat2", 64'(lat), 64'd3);
    check_eq("b2b_block", refill_data, 64'h00000369_00000366);
    check_eq("b2b_pulses", 64'(rv_count - rv0), 64'd2);

    // Reset mid-READ with a store buffered: beat abandoned, store discarded.
    hold_off = 1'b1;
    miss_req = 1'b1; miss_address = 30'h500;
    rd_base = 30'h500; rd_beat = 0;
    tick(); tick();
    wr_req = 1'b1; wr_address = 30'h40; wr_data = 32'h1234;
    tick();
    check_eq("mid_read_store", 64'(last_accept), 64'd1);
    wr_req = 1'b0;
    rst = 1'b1;
    tick();
    check_eq("rst_cut_mem_req", 64'(mif.mem_req), 64'd0);
    tick();
    rst = 1'b0; miss_req = 1'b0; hold_off = 1'b0;
    exp_wr.delete(); shadow = mem_a; rd_beat = 0;
    check_eq("rst2_refill_valid", 64'(refill_valid), 64'd0);
    check_eq("rst2_wbuf_full", 64'(wbuf_full), 64'd0);
    check_eq("rst2_refill_data", refill_data, 64'd0);
    for (int i = 0; i < 3; i++) begin
      check_eq("rst2_no_drain", 64'(mif.mem_req), 64'd0);
      tick();
    end

    // Randomized traffic with random memory latency.
    set_lat(0);
    for (int it = 0; it < 250; it++) begin
      case ($urandom_range(0, 5))
        0, 1, 2: do_store(rand_addr(), $urandom);
        3:       do_miss(rand_addr(), 1'b0, '0, '0, lat, sm);
        4:       do_miss(rand_addr(), 1'b1, rand_addr(), $urandom, lat, sm);
        default: repeat ($urandom_range(1, 3)) tick();
      endcase
    end
    drain();
    do_miss(30'h40, 1'b0, '0, '0, lat, sm);
    check_eq("discarded_store", 64'(refill_data[31:0]), 64'(32'h40 * 32'd3));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
